// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage registers: skid FSM state codes and
// the control/payload widths and bubble control values for each stage boundary.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam int IFID_CTRL_W  = 2;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 12;
  localparam int IDEX_DATA_W  = 96;
  localparam int EXMEM_CTRL_W = 8;
  localparam int EXMEM_DATA_W = 64;
  localparam int MEMWB_CTRL_W = 6;
  localparam int MEMWB_DATA_W = 64;

  // Bubble control vectors must keep reg-write and mem-write deasserted.
  localparam logic [IFID_CTRL_W-1:0]  IFID_NOP_CTRL  = '0;
  localparam logic [IDEX_CTRL_W-1:0]  IDEX_NOP_CTRL  = '0;
  localparam logic [EXMEM_CTRL_W-1:0] EXMEM_NOP_CTRL = '0;
  localparam logic [MEMWB_CTRL_W-1:0] MEMWB_NOP_CTRL = '0;

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, a one-entry skid for
// registered ready, flush-to-bubble and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = 64,
  parameter int                 CTRL_W   = 6,
  parameter logic [CTRL_W-1:0]  NOP_CTRL = '0,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [1:0]        state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              acc, drn;

  assign out_valid = (state_q == ST_ONE) || (state_q == ST_TWO);
  assign acc       = in_valid & in_ready_q;
  assign drn       = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    case (state_q)
      ST_EMPTY: if (acc) begin
        state_d     = ST_ONE;
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
      end
      ST_ONE: begin
        if (acc && drn) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end else if (acc) begin
          state_d     = ST_TWO;
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
        end else if (drn) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: if (drn) begin
        state_d     = ST_ONE;
        main_ctrl_d = skid_ctrl_q;
        main_data_d = skid_data_q;
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush discards the held entries and any concurrent input; payload is left as-is.
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
    end
  end

  assign in_ready_d = (state_d != ST_TWO);

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : NOP_CTRL;
  assign out_data  = main_data_q;
  assign stall_cnt = cnt_q;

endmodule
